// File: rtl/mips_fetch_queue.sv
// Decoupled instruction-fetch front end: sequential PC generation, credit-limited
// requests to a variable-latency imem, and a DEPTH-entry {PC+step, inst} queue.
module mips_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    output logic                     fq_valid,
    input  logic                     fq_ready,
    output logic [XLEN-1:0]          fq_pc,
    output logic [31:0]              fq_inst,
    output logic [XLEN-1:0]          pc_current,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned     AW      = $clog2(DEPTH);
    localparam int unsigned     CW      = AW + 1;
    localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   ra_wr_q, ra_wr_d;
    logic [AW-1:0]   ra_rd_q, ra_rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    // Request addresses of every outstanding access, live or stale, in issue order
    logic [XLEN-1:0] ra_mem   [DEPTH];

    logic            req_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;

    always_comb begin
        credit_used    = {1'b0, count_q} + {1'b0, inflight_q};
        imem_req_valid = rst & ~redirect_valid & (credit_used < DEPTH_W);
        fq_valid       = (count_q != '0) & ~redirect_valid;
        req_fire       = imem_req_valid & imem_req_ready;
        rsp_drop       = redirect_valid | (drop_cnt_q != '0);
        push           = imem_rsp_valid & ~rsp_drop;
        pop            = fq_valid & fq_ready;

        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ra_wr_d    = ra_wr_q;
        ra_rd_d    = ra_rd_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (imem_rsp_valid) ra_rd_d = ra_rd_q + AW'(1);
        if (req_fire) begin
            pc_d    = pc_q + STEP;
            ra_wr_d = ra_wr_q + AW'(1);
        end

        if (redirect_valid) begin
            pc_d       = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (imem_rsp_valid && drop_cnt_q != '0)
                drop_cnt_d = drop_cnt_q - CW'(1);
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ra_wr_q    <= '0;
            ra_rd_q    <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ra_wr_q    <= ra_wr_d;
            ra_rd_q    <= ra_rd_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= ra_mem[ra_rd_q] + STEP;
            inst_mem[wr_ptr_q] <= imem_rsp_data;
        end
        if (req_fire) ra_mem[ra_wr_q] <= pc_q;
    end

    assign imem_req_addr = pc_q;
    assign pc_current    = pc_q;
    assign occupancy     = count_q;
    assign fq_pc         = pc_mem[rd_ptr_q];
    assign fq_inst       = inst_mem[rd_ptr_q];

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Randomized bench for mips_fetch_queue against a queue-based model of the
// fetch front end and an in-order variable-latency instruction memory.
module tb_mips_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              fq_valid;
    logic              fq_ready;
    logic [XLEN-1:0]   fq_pc;
    logic [31:0]       fq_inst;
    logic [XLEN-1:0]   pc_current;
    logic [2:0]        occupancy;

    mips_fetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(4)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .fq_valid(fq_valid), .fq_ready(fq_ready),
        .fq_pc(fq_pc), .fq_inst(fq_inst),
        .pc_current(pc_current), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    ent_t        mq[$];
    req_t        oq[$];
    logic [31:0] m_pc;
    int          cyc;
    int          last_due;
    int          lat_min, lat_max;
    int          p_rdy, p_frdy, p_redir;
    bit          f_redir;
    logic [31:0] f_pc;
    int          compared;
    int          mismatched;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] x;
        x = a * 32'h9E37_79B1;
        return x ^ 32'h5A3C_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        oq.delete();
        m_pc     = 32'h0;
        last_due = cyc;
    endtask

    // Enters and leaves just after a falling edge
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_fqv", 64'(fq_valid), 64'd0);
        chk("rst_req", 64'(imem_req_valid), 64'd0);
        chk("rst_pc", 64'(pc_current), 64'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step();
        bit          exp_req;
        bit          exp_fqv;
        bit          redir;
        bit          rsp;
        int          lat;
        int          due;
        logic [1:0]  lo;
        req_t        r;
        redir = f_redir ? 1'b1 : ($urandom_range(99) < p_redir);
        if (f_redir) redirect_pc = f_pc;
        else if ($urandom_range(3) == 0) begin
            lo = 2'($urandom_range(3));
            redirect_pc = {28'hFFF_FFFF, lo, 2'b00};
        end else redirect_pc = $urandom & 32'hFFFF_FFFC;
        redirect_valid = redir;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        fq_ready       = ($urandom_range(99) < p_frdy);
        rsp = (oq.size() > 0) && (oq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word(oq[0].addr) : $urandom;
        #1;
        exp_req = !redir && (mq.size() + oq.size() < DEPTH);
        exp_fqv = !redir && (mq.size() != 0);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
        chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
        chk("pc_current", 64'(pc_current), 64'(m_pc));
        chk("fq_valid", 64'(fq_valid), 64'(exp_fqv));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        if (exp_fqv) begin
            chk("fq_pc", 64'(fq_pc), 64'(mq[0].pc));
            chk("fq_inst", 64'(fq_inst), 64'(mq[0].inst));
        end
        @(posedge clk);
        if (rsp) begin
            r = oq.pop_front();
            if (!r.stale && !redir)
                mq.push_back('{pc: r.addr + 32'd4, inst: word(r.addr)});
        end
        if (redir) begin
            foreach (oq[i]) oq[i].stale = 1'b1;
            mq.delete();
            m_pc = redirect_pc;
        end else begin
            if (exp_fqv && fq_ready) void'(mq.pop_front());
            if (exp_req && imem_req_ready) begin
                lat = $urandom_range(lat_max, lat_min);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                oq.push_back('{addr: m_pc, due: due, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg(input int lmin, input int lmax, input int pr,
                       input int pf, input int pd);
        lat_min = lmin;
        lat_max = lmax;
        p_rdy   = pr;
        p_frdy  = pf;
        p_redir = pd;
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        cyc            = 0;
        f_redir        = 1'b0;
        f_pc           = '0;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        fq_ready       = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Straight-line streaming at 1-cycle latency
        cfg(1, 1, 100, 100, 0);
        run(12);

        // Stall: queue fills to DEPTH, then issue stops at 0x10
        do_reset();
        cfg(1, 1, 100, 0, 0);
        run(12);
        #1;
        chk("stall_occ", 64'(occupancy), 64'd4);
        chk("stall_req", 64'(imem_req_valid), 64'd0);
        chk("stall_pc", 64'(pc_current), 64'h10);
        chk("stall_head", 64'(fq_pc), 64'h4);
        cfg(1, 1, 100, 100, 0);
        run(8);

        // 3-cycle latency, redirect to 0x100 with requests in flight
        do_reset();
        cfg(3, 3, 100, 100, 0);
        run(2);
        f_redir = 1'b1;
        f_pc    = 32'h100;
        step();
        f_redir = 1'b0;
        run(12);

        // Back-to-back redirects under 2-cycle latency
        do_reset();
        cfg(2, 2, 100, 100, 0);
        run(3);
        f_redir = 1'b1;
        f_pc    = 32'h200;
        step();
        f_pc    = 32'h300;
        step();
        f_redir = 1'b0;
        run(12);

        // Reset asserted with 3 entries queued
        do_reset();
        cfg(1, 1, 100, 0, 0);
        for (int i = 0; i < 20 && mq.size() != 3; i++) step();
        chk("fill3", 64'(mq.size()), 64'd3);
        do_reset();
        cfg(1, 1, 100, 100, 0);
        run(10);

        // Randomized mixes of latency, back-pressure and redirects
        for (int k = 0; k < 8; k++) begin
            cfg($urandom_range(2, 1), $urandom_range(6, 2),
                $urandom_range(100, 30), $urandom_range(100, 20),
                $urandom_range(15, 0));
            run(400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
